// File: rtl/uart_pkg.sv
// uart_pkg: shared types and frame constants for the UART transmit path.
// Optional feature macro: UART_TX_PARITY_EN (adds an even-parity bit per frame).
package uart_pkg;

    // Transmitter FSM states; the encoding is shared with the scheduler's legacy state constants.
    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_LOAD   = 3'd1,
        TX_START  = 3'd2,
        TX_DATA   = 3'd3,
`ifdef UART_TX_PARITY_EN
        TX_PARITY = 3'd5,
`endif
        TX_STOP   = 3'd4
    } tx_state_t;

    localparam int START_BITS = 1;
    localparam int STOP_BITS  = 1;

`ifdef UART_TX_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    // Number of baud ticks one frame occupies on the line.
    function automatic int frame_ticks(input int data_w);
        return START_BITS + data_w + PARITY_BITS + STOP_BITS;
    endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// uart_tx_sched_if: request/acknowledge bundle between the clients and the
// shared UART transmit scheduler.
interface uart_tx_sched_if #(
    parameter int NREQ   = 4,
    parameter int DATA_W = 8
);
    localparam int OWN_W = $clog2(NREQ);

    logic [NREQ-1:0]        req;
    logic [NREQ*DATA_W-1:0] data;
    logic [NREQ-1:0]        ack;
    logic [OWN_W-1:0]       owner;

    // Clients present requests and payloads.
    modport master (
        output req,
        output data,
        input  ack,
        input  owner
    );

    // The scheduler grants and acknowledges.
    modport slave (
        input  req,
        input  data,
        output ack,
        output owner
    );
endinterface

// File: rtl/uart_tx_sched_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first set request at or
// after ptr, searching upward and wrapping. Output is one-hot (or zero).
module rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int PTR_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt
);
    int best;

    // Find the smallest wrapped distance from ptr among active requests, then grant that slot.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
        gnt  = '0;
        best = NREQ;
        for (int k = 0; k < NREQ; k++) begin
            if (req[k]) begin
                if (((k >= int'(ptr)) ? (k - int'(ptr)) : (k + NREQ - int'(ptr))) < best) begin
                    best = (k >= int'(ptr)) ? (k - int'(ptr)) : (k + NREQ - int'(ptr));
                end
            end
        end
        for (int k = 0; k < NREQ; k++) begin
            gnt[k] = req[k] &&
                     (((k >= int'(ptr)) ? (k - int'(ptr)) : (k + NREQ - int'(ptr))) == best);
        end
    end
endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler that shares one baud generator and one
// UART transmit line among NREQ clients. Frames are start, DATA_W bits LSB
// first, optional even parity, stop; each bit lasts one clk_bps tick period.
// Optional feature macro: UART_TX_PARITY_EN (even-parity bit before stop).
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int DATA_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    uart_tx_sched_if.slave cli,
    output logic           bps_start,
    input  logic           clk_bps,
    output logic           txd,
    output logic           busy,
    output logic           done
);
    localparam int OWN_W = $clog2(NREQ);
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W);

    localparam logic [2:0] ST_IDLE   = TX_IDLE;
    localparam logic [2:0] ST_LOAD   = TX_LOAD;
    localparam logic [2:0] ST_START  = TX_START;
    localparam logic [2:0] ST_DATA   = TX_DATA;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] ST_PARITY = TX_PARITY;
`endif
    localparam logic [2:0] ST_STOP   = TX_STOP;

    logic [2:0]        state_q, state_d;
    logic [OWN_W-1:0]  ptr_q, ptr_d;
    logic [OWN_W-1:0]  owner_q, owner_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]  bitcnt_q, bitcnt_d;
    logic              txd_q, txd_d;
    logic              bps_q, bps_d;
    logic              busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    logic [NREQ-1:0]   gnt;
    logic [OWN_W-1:0]  gnt_idx;
    logic [DATA_W-1:0] sel_data;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req (cli.req),
        .ptr (ptr_q),
        .gnt (gnt)
    );

    // Encode the one-hot grant and route the granted slot's payload.
    always_comb begin
        gnt_idx  = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                gnt_idx  = OWN_W'(i);
                sel_data = cli.data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state and output logic; clk_bps only advances the frame once the start bit is on the line.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        ack_d    = '0;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        txd_d    = txd_q;
        bps_d    = bps_q;
        busy_d   = busy_q;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                txd_d = 1'b1;
                bps_d = 1'b0;
                if (|cli.req) begin
                    // Capture on the edge into LOAD so ack and the start bit are visible during LOAD.
                    state_d  = ST_LOAD;
                    ack_d    = gnt;
                    owner_d  = gnt_idx;
                    ptr_d    = (gnt_idx == OWN_W'(NREQ - 1)) ? '0 : gnt_idx + OWN_W'(1);
                    shreg_d  = sel_data;
                    bitcnt_d = '0;
                    bps_d    = 1'b1;
                    busy_d   = 1'b1;
                    txd_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^sel_data;
`endif
                end
            end
            ST_LOAD: begin
                // A tick landing here belongs to the generator's restart and is ignored.
                state_d = ST_START;
            end
            ST_START: begin
                if (clk_bps) begin
                    txd_d    = shreg_q[0];
                    shreg_d  = shreg_q >> 1;
                    bitcnt_d = CNT_W'(1);
                    state_d  = ST_DATA;
                end
            end
            ST_DATA: begin
                if (clk_bps) begin
                    if (bitcnt_q < LAST_BIT) begin
                        txd_d    = shreg_q[0];
                        shreg_d  = shreg_q >> 1;
                        bitcnt_d = bitcnt_q + CNT_W'(1);
                    end else begin
`ifdef UART_TX_PARITY_EN
                        txd_d   = parity_q;
                        state_d = ST_PARITY;
`else
                        txd_d   = 1'b1;
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (clk_bps) begin
                    txd_d   = 1'b1;
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (clk_bps) begin
                    bps_d   = 1'b0;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                txd_d   = 1'b1;
                bps_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Control state with synchronous reset; a reset mid-frame drops the line back to idle.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make every register update from the pre-edge values, independent of statement order.
        if (rst) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            owner_q  <= '0;
            ack_q    <= '0;
            bitcnt_q <= '0;
            txd_q    <= 1'b1;
            bps_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            ack_q    <= ack_d;
            bitcnt_q <= bitcnt_d;
            txd_q    <= txd_d;
            bps_q    <= bps_d;
            busy_q   <= busy_d;
        end
    end

    // Payload datapath; always overwritten at capture before it is shifted out.
    always_ff @(posedge clk) begin
        // NOTE: no reset here on purpose; the shift register's contents are never observed before a capture loads it.
        shreg_q  <= shreg_d;
`ifdef UART_TX_PARITY_EN
        parity_q <= parity_d;
`endif
    end

    assign cli.ack   = ack_q;
    assign cli.owner = owner_q;
    assign bps_start = bps_q;
    assign txd       = txd_q;
    assign busy      = busy_q;
    // The end-of-frame pulse coincides with the stop bit's closing tick, two cycles ahead of the next ack.
    assign done      = (state_q == ST_STOP) && clk_bps && !rst;

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed self-checking bench for uart_tx_sched with
// NREQ=4, DATA_W=8 and baud ticks every 16 clocks.
// Honours UART_TX_PARITY_EN for the frame length and the parity test.
module tb_uart_tx_sched;
    localparam int TICK_GAP = 16;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_TICKS = 11;
    localparam logic [10:0] SB_BITS  = 11'b1_0_10100101_0;
    localparam logic [10:0] PAR_BITS = 11'b1_1_00000111_0;
`else
    localparam int FRAME_TICKS = 10;
    localparam logic [9:0] SB_BITS = 10'b1_10100101_0;
`endif

    logic clk;
    logic rst;
    logic clk_bps;
    logic bps_start;
    logic txd;
    logic busy;
    logic done;

    int n_checks;
    int n_fail;

    uart_tx_sched_if #(.NREQ(4), .DATA_W(8)) bus ();

    uart_tx_sched #(.NREQ(4), .DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .cli       (bus),
        .bps_start (bps_start),
        .clk_bps   (clk_bps),
        .txd       (txd),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Line bits in time order: index 0 is the start bit.
    function automatic logic [FRAME_TICKS-1:0] frame_bits(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^d, d, 1'b0};
`else
        return {1'b1, d, 1'b0};
`endif
    endfunction

    // Drive a full frame of ticks; check each bit just before its closing tick and done on the last.
    task automatic run_frame(input logic [FRAME_TICKS-1:0] exp_bits, input string tag);
        for (int k = 0; k < FRAME_TICKS; k++) begin
            repeat (TICK_GAP - 1) @(negedge clk);
            check($sformatf("%s_bit%0d", tag, k), txd, exp_bits[k]);
            check($sformatf("%s_bps%0d", tag, k), bps_start, 1'b1);
            clk_bps = 1'b1;
            #1;
            check($sformatf("%s_done%0d", tag, k), done, (k == FRAME_TICKS - 1));
            @(negedge clk);
            clk_bps = 1'b0;
        end
        check({tag, "_end_bps"}, bps_start, 1'b0);
        check({tag, "_end_busy"}, busy, 1'b0);
        check({tag, "_end_txd"}, txd, 1'b1);
        check({tag, "_end_done"}, done, 1'b0);
    endtask

    task automatic expect_grant(input string tag, input logic [3:0] g, input logic [1:0] own);
        check({tag, "_ack"}, bus.ack, g);
        check({tag, "_owner"}, bus.owner, own);
        check({tag, "_start"}, txd, 1'b0);
        check({tag, "_busy"}, busy, 1'b1);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        clk_bps  = 1'b0;
        bus.req  = '0;
        bus.data = '0;
        repeat (3) @(negedge clk);

        // Reset values.
        check("rst_txd", txd, 1'b1);
        check("rst_bps", bps_start, 1'b0);
        check("rst_ack", bus.ack, 4'b0000);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_owner", bus.owner, 2'd0);
        rst = 1'b0;

        // Single byte A5 from slot 0.
        bus.data[7:0] = 8'hA5;
        bus.req       = 4'b0001;
        @(negedge clk);
        expect_grant("sb", 4'b0001, 2'd0);
        check("sb_bps_load", bps_start, 1'b1);
        bus.req = 4'b0000;
        @(negedge clk);
        check("sb_ack_pulse", bus.ack, 4'b0000);
        run_frame(SB_BITS, "sb");

        // Round-robin from a fresh pointer: 0,1,3,0 with req=1011.
        rst = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        bus.data = {8'h0F, 8'h00, 8'h3C, 8'hA5};
        bus.req  = 4'b1011;
        @(negedge clk);
        expect_grant("rr0", 4'b0001, 2'd0);
        bus.req = 4'b1010;
        @(negedge clk);
        bus.req = 4'b1011;
        run_frame(frame_bits(8'hA5), "rr0");
        check("rr0_gap", bus.ack, 4'b0000);
        @(negedge clk);
        expect_grant("rr1", 4'b0010, 2'd1);
        bus.req = 4'b1001;
        @(negedge clk);
        bus.req = 4'b1011;
        run_frame(frame_bits(8'h3C), "rr1");
        check("rr1_gap", bus.ack, 4'b0000);
        @(negedge clk);
        expect_grant("rr3", 4'b1000, 2'd3);
        bus.req = 4'b0011;
        @(negedge clk);
        bus.req = 4'b1011;
        run_frame(frame_bits(8'h0F), "rr3");
        check("rr3_gap", bus.ack, 4'b0000);
        @(negedge clk);
        expect_grant("rr0b", 4'b0001, 2'd0);

        // Withdrawal: req[2] pulsed for one cycle during the frame owned by 0.
        bus.req = 4'b0000;
        @(negedge clk);
        bus.req = 4'b0100;
        @(negedge clk);
        bus.req = 4'b0000;
        run_frame(frame_bits(8'hA5), "wd");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("wd_ack_%0d", i), bus.ack, 4'b0000);
            check($sformatf("wd_txd_%0d", i), txd, 1'b1);
            check($sformatf("wd_bps_%0d", i), bps_start, 1'b0);
        end

        // Reset mid-frame after the 4th tick, slot 1 transmitting 3C.
        bus.req = 4'b0010;
        @(negedge clk);
        expect_grant("mr", 4'b0010, 2'd1);
        bus.req = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            repeat (TICK_GAP - 1) @(negedge clk);
            check($sformatf("mr_bit%0d", k), txd, frame_bits(8'h3C) >> k & 1);
            clk_bps = 1'b1;
            @(negedge clk);
            clk_bps = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        check("mr_txd", txd, 1'b1);
        check("mr_bps", bps_start, 1'b0);
        check("mr_busy", busy, 1'b0);
        check("mr_done", done, 1'b0);
        check("mr_owner", bus.owner, 2'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            clk_bps = 1'b1;
            #1;
            check($sformatf("mr_nodone_%0d", i), done, 1'b0);
            @(negedge clk);
        end
        clk_bps = 1'b0;
        bus.req = 4'b1011;
        @(negedge clk);
        expect_grant("mr_after", 4'b0001, 2'd0);
        bus.req = 4'b0000;
        run_frame(frame_bits(8'hA5), "mr_after");

        // Tick coinciding with LOAD is ignored; slot 2 sends C3.
        bus.data[23:16] = 8'hC3;
        bus.req         = 4'b0100;
        @(negedge clk);
        expect_grant("ta", 4'b0100, 2'd2);
        clk_bps = 1'b1;
        bus.req = 4'b0000;
        @(negedge clk);
        clk_bps = 1'b0;
        check("ta_start_held", txd, 1'b0);
        run_frame(frame_bits(8'hC3), "ta");

`ifdef UART_TX_PARITY_EN
        // Parity: 07 has three ones, so the even-parity bit is 1.
        bus.data[31:24] = 8'h07;
        bus.req         = 4'b1000;
        @(negedge clk);
        expect_grant("par", 4'b1000, 2'd3);
        bus.req = 4'b0000;
        run_frame(PAR_BITS, "par");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Shared-transmitter scheduler for the UART path. Several requesters each present a byte. The block picks one by round-robin, owns the baud generator's `bps_start` enable, and serializes the byte onto `txd` on every baud tick `clk_bps`. It sits between client logic and the single baud generator and transmit line, so the rest of the design needs no knowledge of bit timing.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..8.
- `DATA_W`, 8: data bits per frame, 5..8.

Ports:
- `clk` input 1: system clock, all logic on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req` input NREQ: request vector. `req[i]` is held high until `ack[i]`.
- `data` input NREQ*DATA_W: request payloads. Slot i is `data[i*DATA_W +: DATA_W]`, stable while `req[i]` is high.
- `ack` output NREQ: one-hot, one-cycle pulse when the slot's byte is captured.
- `owner` output clog2(NREQ): index of the current or last granted requester.
- `bps_start` output 1: enable to the baud generator. High for the whole frame.
- `clk_bps` input 1: one-cycle baud tick from the generator.
- `txd` output 1: serial line, idle high.
- `busy` output 1: high from capture until the frame ends.
- `done` output 1: one-cycle pulse at the end of the frame.

## Operation
States are IDLE, LOAD, START, DATA, STOP.

- **IDLE**
  - `txd`=1 and `bps_start`=0.
  - If `req` is non-zero, the arbiter picks the first set bit at or after `ptr`, searching upward and wrapping.
  - Go to LOAD.
- **LOAD** (one cycle)
  - Capture the selected slot into `shreg`.
  - Pulse the `ack` bit, set `owner`, set `ptr` = grant+1 mod NREQ.
  - Set `bps_start`=1, `busy`=1, `txd`=0 (start bit).
  - Go to START.
- **START**
  - On `clk_bps`: `txd`=`shreg[0]`, shift right, `bitcnt`=1.
  - Go to DATA.
- **DATA**
  - On `clk_bps`, while `bitcnt` < DATA_W: `txd`=`shreg[0]`, shift, `bitcnt`+1.
  - On `clk_bps` when `bitcnt`==DATA_W: `txd`=1 (stop bit).
  - Go to STOP.
- **STOP**
  - On `clk_bps`: `bps_start`=0, `busy`=0, pulse `done`.
  - Go to IDLE.

Rules:
- `clk_bps` is ignored in IDLE and LOAD.
- Between ticks, every state holds its outputs.
- `req` is sampled only in IDLE. Dropping `req[i]` before `ack` withdraws that request without error. Changes to `req` during a frame do not affect the frame.
- `bitcnt` is clog2(DATA_W+1) bits wide and is cleared in LOAD.
- The data bits go out LSB first.

## Timing
- Reset values:
  - `txd`=1, `bps_start`=0, `ack`=0, `busy`=0, `done`=0, `owner`=0.
  - `ptr`=0, state IDLE.
- Reset asserted mid-frame takes effect on the next edge: the frame is truncated with `txd`=1, and no `done` or `ack` is produced.
- Latency:
  - From `req` high in IDLE to `ack`: 1 cycle, in LOAD.
  - `txd` falls in the same cycle as `ack` (registered at the LOAD edge).
- Frame length:
  - DATA_W+2 `clk_bps` ticks, 10 for DATA_W=8.
  - Each bit lasts one tick period. The first bit spans LOAD to the first tick.
- IDLE lasts at least 1 cycle between frames with `bps_start`=0. This guarantees the generator counter reset.
- Back-to-back requests: the next `ack` follows `done` by exactly 2 cycles (STOP→IDLE→LOAD).
- A `clk_bps` coinciding with the LOAD cycle is ignored.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - Adds a PARITY state between DATA and STOP.
  - `txd` = even parity (XOR of the DATA_W bits), computed at LOAD.
  - Frame = DATA_W+3 ticks.
- Undefined:
  - No parity state or parity logic.
  - Frame = DATA_W+2 ticks.

## Structure
- Shared package `uart_pkg` holds:
  - the state enumeration `tx_state_t`;
  - the frame constants `START_BITS`=1 and `STOP_BITS`=1;
  - the helper `frame_ticks(DATA_W)`, which includes the parity term under the macro.
- Sub-module `rr_arbiter`:
  - parameter NREQ;
  - inputs `req` and `ptr`, output one-hot `gnt`;
  - purely combinational, instantiated once.
- Pointer update and capture stay in `uart_tx_sched`.

## Test plan
- **Single byte:** `req`=4'b0001, `data[7:0]`=8'hA5, ticks every 16 cycles.
  - `ack`=0001 one cycle later.
  - `txd` bits = 0,1,0,1,0,0,1,0,1,1.
  - `done` after the 10th tick; `bps_start` low the next cycle.
- **Round-robin:** `req`=4'b1011 held, re-asserted after each `ack`.
  - Grant order is 0,1,3,0.
  - `owner` matches each grant.
  - `ack` follows the previous `done` by 2 cycles.
- **Withdrawal:** `req[2]` pulsed for 1 cycle during a frame owned by 0.
  - No `ack[2]`; `ack[2]` stays 0.
  - IDLE is entered and `txd` stays 1.
- **Reset mid-frame:** `rst` high after the 4th tick.
  - `txd`=1, `bps_start`=0, `busy`=0 on the next edge.
  - No `done`.
  - The first grant afterwards is slot 0.
- **Tick alignment:** `clk_bps` asserted in the LOAD cycle.
  - The start bit is not shortened; the bit counter advances only on later ticks.
  - Total frame = 10 ticks after LOAD.
- **Parity (`UART_TX_PARITY_EN`):** `data`=8'h07.
  - Parity bit = 1.
  - 11 ticks per frame; stop bit after the parity bit.
